// File: rtl/banner_scroll_reader.sv
// Banner ROM reader: fetches every row once per frame tick, extracts a wrapping
// WIN-column window at the scroll offset and hands rows out over valid/ready.
module banner_scroll_reader #(
    parameter int ROWS = 15,
    parameter int COLS = 70,
    parameter int WIN  = 16,
    parameter int STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_tick,
    output logic [4:0]      rom_address,
    input  logic [COLS-1:0] rom_data,
    output logic            row_valid,
    input  logic            row_ready,
    output logic [3:0]      row_index,
    output logic [WIN-1:0]  row_pixels,
    output logic [6:0]      offset,
    output logic            busy,
    output logic            overrun
);
    localparam int AW = $clog2(COLS);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, PRESENT} state_t;

    state_t         state, state_d;
    logic [3:0]     r;
    logic           start, capture, next_row, frame_done;
    logic           hs;
    logic [WIN-1:0] win_pix;
    logic [7:0]     off_sum;
    logic [6:0]     offset_nxt;

    assign hs   = row_valid && row_ready;
    assign busy = (state != IDLE);

    // Column c of the window maps to ROM column (offset+c) mod COLS; c < WIN <= COLS
    // keeps the sum below 2*COLS so one conditional subtract is enough.
    for (genvar c = 0; c < WIN; c++) begin : g_win
        logic [7:0]    sum, idx;
        logic [AW-1:0] pos;
        assign sum = {1'b0, offset} + 8'(c);
        assign idx = (sum >= 8'(COLS)) ? sum - 8'(COLS) : sum;
        assign pos = AW'(COLS - 1) - AW'(idx);
        assign win_pix[WIN-1-c] = rom_data[pos];
    end

    assign off_sum    = {1'b0, offset} + 8'(STEP);
    assign offset_nxt = (off_sum >= 8'(COLS)) ? 7'(off_sum - 8'(COLS)) : off_sum[6:0];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d    = state;
        start      = 1'b0;
        capture    = 1'b0;
        next_row   = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: if (frame_tick) begin
                state_d = ISSUE;
                start   = 1'b1;
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                state_d = PRESENT;
                capture = 1'b1;
            end
            PRESENT: if (hs) begin
                if (r == 4'(ROWS - 1)) begin
                    state_d    = IDLE;
                    frame_done = 1'b1;
                end else begin
                    state_d  = ISSUE;
                    next_row = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_address <= '0;
            r           <= '0;
            row_valid   <= 1'b0;
            row_index   <= '0;
            row_pixels  <= '0;
            offset      <= '0;
            overrun     <= 1'b0;
        end else begin
            if (frame_tick && state != IDLE) overrun <= 1'b1;
            if (start) begin
                rom_address <= '0;
                r           <= '0;
            end
            if (next_row) begin
                r           <= r + 4'd1;
                rom_address <= {1'b0, r} + 5'd1;
            end
            if (capture) begin
                row_pixels <= win_pix;
                row_index  <= r;
                row_valid  <= 1'b1;
            end
            if (next_row || frame_done) row_valid <= 1'b0;
            if (frame_done) offset <= offset_nxt;
        end
    end
endmodule

// File: tb/tb_banner_scroll_reader.sv
// Randomized bench for banner_scroll_reader: a row-level reference model is
// compared against the DUT every cycle, plus literal checks on known windows.
module tb_banner_scroll_reader;
    localparam int ROWS = 15, COLS = 70, WIN = 16, STEP = 1;

    logic            clk = 1'b0;
    logic            rst, frame_tick, row_ready;
    logic [4:0]      rom_address;
    logic [COLS-1:0] rom_data;
    logic            row_valid, busy, overrun;
    logic [3:0]      row_index;
    logic [WIN-1:0]  row_pixels;
    logic [6:0]      offset;

    logic [COLS-1:0] rom [ROWS];
    int n_vec = 0, n_err = 0;
    int frame_cycles;
    logic [WIN-1:0] cap0;

    // reference model state
    bit m_busy = 0, m_ovr = 0;
    int m_row = 0, m_wait = 0, m_off = 0, m_addr = 0;

    banner_scroll_reader #(.ROWS(ROWS), .COLS(COLS), .WIN(WIN), .STEP(STEP)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .rom_address(rom_address),
        .rom_data(rom_data), .row_valid(row_valid), .row_ready(row_ready),
        .row_index(row_index), .row_pixels(row_pixels), .offset(offset),
        .busy(busy), .overrun(overrun));

    always #5 clk = ~clk;

    always @(posedge clk)
        rom_data <= (rom_address < 5'(ROWS)) ? rom[rom_address] : '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIN-1:0] win_of(input int row, input int off);
        logic [WIN-1:0] w;
        for (int c = 0; c < WIN; c++) w[WIN-1-c] = rom[row][COLS-1-((off + c) % COLS)];
        return w;
    endfunction

    // Compare against the model, then advance the model through the coming edge.
    always @(negedge clk) begin
        bit m_valid;
        m_valid = m_busy && (m_wait == 0);
        chk("busy", 128'(busy), 128'(m_busy));
        chk("row_valid", 128'(row_valid), 128'(m_valid));
        chk("offset", 128'(offset), 128'(m_off));
        chk("overrun", 128'(overrun), 128'(m_ovr));
        chk("rom_address", 128'(rom_address), 128'(m_addr));
        if (m_valid) begin
            chk("row_index", 128'(row_index), 128'(m_row));
            chk("row_pixels", 128'(row_pixels), 128'(win_of(m_row, m_off)));
        end
        if (rst) begin
            m_busy = 0; m_ovr = 0; m_row = 0; m_wait = 0; m_off = 0; m_addr = 0;
        end else begin
            if (frame_tick && m_busy) m_ovr = 1;
            if (!m_busy) begin
                if (frame_tick) begin
                    m_busy = 1; m_row = 0; m_wait = 2; m_addr = 0;
                end
            end else if (m_wait > 0) begin
                m_wait--;
            end else if (row_ready) begin
                if (m_row == ROWS - 1) begin
                    m_busy = 0;
                    m_off = (m_off + STEP) % COLS;
                end else begin
                    m_row++; m_addr = m_row; m_wait = 2;
                end
            end
        end
    end

    // mode 0: ready high; 1: random ready; 2: ready high except a 10-cycle stall on row 5
    task automatic run_frame(input int mode, input int tick_row, input int rst_row);
        bit ticked = 0, done = 0;
        int stall = 0;
        frame_cycles = 0;
        frame_tick = 1; rst = 0; row_ready = 1;
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk); #1;
            frame_tick = 0;
            if (!busy) begin done = 1; break; end
            frame_cycles++;
            if (row_valid && row_index == 0) cap0 = row_pixels;
            if (rst_row >= 0 && row_valid && row_index == 4'(rst_row)) begin
                rst = 1; row_ready = 0;
                @(posedge clk); #1;
                rst = 0; done = 1;
                break;
            end
            row_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (mode == 2 && row_valid && row_index == 5 && stall < 10) begin
                row_ready = 0; stall++;
            end
            if (tick_row >= 0 && !ticked && row_valid && row_index == 4'(tick_row)) begin
                frame_tick = 1; ticked = 1; row_ready = 1;
            end
        end
        if (!done) chk("frame_timeout", 128'(1), 128'(0));
        row_ready = 1;
        @(posedge clk); #1;
    endtask

    task automatic rand_rom();
        for (int i = 0; i < ROWS; i++)
            rom[i] = {$urandom(), $urandom(), $urandom()};
    endtask

    initial begin
        rst = 1; frame_tick = 0; row_ready = 1;
        for (int i = 0; i < ROWS; i++) rom[i] = COLS'(1) << i;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        #1;
        chk("reset_addr", 128'(rom_address), 128'(0));
        chk("reset_valid", 128'(row_valid), 128'(0));
        chk("reset_pixels", 128'(row_pixels), 128'(0));
        chk("reset_offset", 128'(offset), 128'(0));
        chk("reset_busy", 128'(busy), 128'(0));
        @(posedge clk); #1;

        run_frame(0, -1, -1);
        chk("frame_len", 128'(frame_cycles), 128'(45));
        chk("offset_after_1", 128'(offset), 128'(1));

        for (int k = 0; k < 6; k++) begin
            rand_rom();
            run_frame(1, -1, -1);
        end
        run_frame(2, -1, -1);

        run_frame(0, 3, -1);
        chk("overrun_set", 128'(overrun), 128'(1));
        run_frame(1, -1, -1);
        run_frame(0, 14, -1);
        chk("overrun_sticky", 128'(overrun), 128'(1));

        run_frame(1, -1, 7);
        chk("midrst_valid", 128'(row_valid), 128'(0));
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_offset", 128'(offset), 128'(0));
        chk("midrst_overrun", 128'(overrun), 128'(0));

        rand_rom();
        rom[0] = COLS'(1);
        run_frame(0, -1, -1);
        chk("win_off0", 128'(cap0), 128'(16'h0000));
        for (int k = 0; k < 59; k++) run_frame(0, -1, -1);
        chk("offset_60", 128'(offset), 128'(60));
        run_frame(1, -1, -1);
        chk("win_off60", 128'(cap0), 128'(16'h0040));
        for (int k = 0; k < 8; k++) run_frame(0, -1, -1);
        chk("offset_69", 128'(offset), 128'(69));
        run_frame(1, -1, -1);
        chk("win_off69", 128'(cap0), 128'(16'h8000));
        chk("offset_wrap", 128'(offset), 128'(0));

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
